// File: rtl/uart_rx_if.sv
// Receive-side signal bundle between the UART RX frame decoder and its host/FIFO.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_in;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx_in,
        input  rx_data, rx_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  rx_in,
        output rx_data, rx_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receiver: start detect, mid-bit sampling, LSB-first shift, parity/stop checks.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave rx_if
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be even and >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("DATA_BITS must be 5..9");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rxs;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    assign rxs = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], rx_if.rx_in};
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        armed_d     = armed_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A falling edge only counts once the line has been seen high (breaks stay single)
                armed_d = rxs;
                cnt_d   = '0;
                bit_d   = '0;
                if (armed_q && !rxs) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = S_IDLE;
                        armed_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    sh_d  = {rxs, sh_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d     = '0;
                    par_bad_d = ((^sh_q) ^ rxs) != PAR_ODD;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                    armed_d     = rxs;
                    rx_valid_d  = 1'b1;
                    rx_data_d   = sh_q;
                    frame_err_d = !rxs;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_bad_q;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            armed_q     <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            armed_q     <= armed_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = parity_err_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: line-level frame generator, expected-result queue, monitor.
module tb_uart_rx_frame;
    localparam int CPB = 16;
    localparam int DB  = 8;
    localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    // Start edge to rx_valid: half start bit + full data/parity/stop bits, plus sync and output flop
    localparam int LAT = CPB * (DB + NPAR + 1) + CPB / 2 + 3;

    typedef struct {
        logic [DB-1:0] data;
        logic          perr;
        logic          ferr;
        int            start;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   sent = 0;
    logic last_perr = 1'b0;
    logic last_ferr = 1'b0;
    exp_t exp_q[$];

    uart_rx_if #(.DATA_BITS(DB)) u_if ();

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(PODD)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (u_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && u_if.rx_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual data=%0h required=no pulse", u_if.rx_data);
            end else begin
                e = exp_q.pop_front();
                chk("rx_data", int'(u_if.rx_data), int'(e.data));
                chk("parity_err", int'(u_if.parity_err), int'(e.perr));
                chk("frame_err", int'(u_if.frame_err), int'(e.ferr));
                chk("latency", cyc - e.start, LAT);
            end
        end
    end

    // All line drivers start and end 1 time unit after a rising edge
    task automatic drive_bit(input logic b);
        u_if.rx_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input bit flip_par, input logic stop_bit);
        exp_t  e;
        logic  pbit;
        pbit    = ((^d) ^ PODD[0]) ^ flip_par;
        e.data  = d;
        e.perr  = (NPAR == 1) ? (((^d) ^ pbit) != PODD[0]) : 1'b0;
        e.ferr  = !stop_bit;
        e.start = cyc;
        exp_q.push_back(e);
        sent++;
        last_perr = e.perr;
        last_ferr = e.ferr;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        if (NPAR == 1) drive_bit(pbit);
        drive_bit(stop_bit);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4 * CPB && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stim
        int   p0;
        bit   seen_idle;
        logic [DB-1:0] d;
        u_if.rx_in = 1'b1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_data", int'(u_if.rx_data), 0);
        chk("reset_valid", int'(u_if.rx_valid), 0);
        chk("reset_perr", int'(u_if.parity_err), 0);
        chk("reset_ferr", int'(u_if.frame_err), 0);
        chk("reset_busy", int'(u_if.busy), 0);
        rst = 1'b0;
        idle_bits(2);

        send_frame(8'hA5, 1'b0, 1'b1);
        idle_bits(2);
        drain("drain_a5");

        p0 = pulses;
        u_if.rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        u_if.rx_in = 1'b1;
        seen_idle = 1'b0;
        for (int i = 0; i < 8 && !seen_idle; i++) begin
            @(posedge clk);
            #1;
            if (!u_if.busy) seen_idle = 1'b1;
        end
        chk("glitch_busy_clear", int'(seen_idle), 1);
        idle_bits(3);
        chk("glitch_no_pulse", pulses - p0, 0);
        chk("glitch_perr_held", int'(u_if.parity_err), int'(last_perr));
        chk("glitch_ferr_held", int'(u_if.frame_err), int'(last_ferr));
        chk("glitch_data_held", int'(u_if.rx_data), 8'hA5);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h3C, 1'b1, 1'b1);
        idle_bits(2);
        drain("drain_3c");
`endif

        send_frame(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive_bit(1'b0);
        drain("drain_break");
        idle_bits(4);
        send_frame(8'h55, 1'b0, 1'b1);
        idle_bits(1);
        drain("drain_55");

        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle_bits(2);
        drain("drain_b2b");

        for (int n = 0; n < 24; n++) begin
            d = DB'($urandom_range(0, (1 << DB) - 1));
            send_frame(d, (NPAR == 1) && ($urandom_range(0, 3) == 0), 1'b1);
            idle_bits($urandom_range(0, 2));
        end
        idle_bits(1);
        drain("drain_random");

        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        repeat (CPB / 2) @(posedge clk);
        #1;
        chk("mid_frame_busy", int'(u_if.busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_data", int'(u_if.rx_data), 0);
        chk("rst_valid", int'(u_if.rx_valid), 0);
        chk("rst_perr", int'(u_if.parity_err), 0);
        chk("rst_ferr", int'(u_if.frame_err), 0);
        chk("rst_busy", int'(u_if.busy), 0);
        u_if.rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_bits(2);
        send_frame(8'h7E, 1'b0, 1'b1);
        idle_bits(2);
        drain("drain_7e");

        chk("pulse_count", pulses, sent);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
